// File: rtl/stopwatch_mmss_counter.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_mmss_counter
// Description : Timebase and BCD MM:SS up/down counter for the board stopwatch.
//               An internal prescaler divides CLOCK_50 down to the count rate.
//               Single-cycle command pulses start/pause, reverse and clear the
//               count. The four digits feed the seven-segment decoders.
// Ports       : CLOCK_50        system clock, rising edge
//               reset_n         synchronous active-low reset
//               run_tgl         pulse: toggle run/pause
//               dir_tgl         pulse: toggle count direction
//               clear           pulse: zero digits and prescaler
//               m1/m0/s1/s0     BCD digits MM:SS
//               up              1 = counting up
//               running         1 = counting enabled
//               tick            one-cycle pulse per count event
//               wrap            one-cycle pulse on 59:59<->00:00 rollover
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_mmss_counter #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       run_tgl,
  input  logic       dir_tgl,
  input  logic       clear,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       up,
  output logic       running,
  output logic       tick,
  output logic       wrap
);

  localparam int              DIV       = CLK_HZ / TICK_HZ;
  localparam int              PW        = $clog2(DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
  localparam logic [3:0]      C_NINE    = 4'd9;
  localparam logic [3:0]      C_FIVE    = 4'd5;

  // Registered state
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    m1_q, m1_d;
  logic [3:0]    m0_q, m0_d;
  logic [3:0]    s1_q, s1_d;
  logic [3:0]    s0_q, s0_d;
  logic          up_q, up_d;
  logic          running_q, running_d;

  // Combinational helpers
  logic          tick_w;
  logic          wrap_w;
  logic          at_max_w;
  logic          at_zero_w;
  logic [3:0]    m1_step, m0_step, s1_step, s0_step;

  // Digit increment with rollover at lim.
  function automatic logic [3:0] bcd_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d == lim) ? 4'd0 : d + 4'd1;
  endfunction

  // Digit decrement with rollunder to lim.
  function automatic logic [3:0] bcd_dec(input logic [3:0] d, input logic [3:0] lim);
    return (d == 4'd0) ? lim : d - 4'd1;
  endfunction

  // Clear suppresses the tick in the same cycle, so wrap is suppressed too.
  always_comb begin
    at_max_w  = (m1_q == C_FIVE) && (m0_q == C_NINE) &&
                (s1_q == C_FIVE) && (s0_q == C_NINE);
    at_zero_w = (m1_q == 4'd0) && (m0_q == 4'd0) &&
                (s1_q == 4'd0) && (s0_q == 4'd0);
    tick_w    = running_q && (presc_q == PRESC_MAX) && !clear;
    wrap_w    = tick_w && (up_q ? at_max_w : at_zero_w);
  end

  // One count step in the current direction. A digit moves only when every
  // lower digit is rolling over (up) or rolling under (down).
  always_comb begin
    m1_step = m1_q;
    m0_step = m0_q;
    s1_step = s1_q;
    s0_step = s0_q;
    if (up_q) begin
      s0_step = bcd_inc(s0_q, C_NINE);
      if (s0_q == C_NINE) begin
        s1_step = bcd_inc(s1_q, C_FIVE);
        if (s1_q == C_FIVE) begin
          m0_step = bcd_inc(m0_q, C_NINE);
          if (m0_q == C_NINE) begin
            m1_step = bcd_inc(m1_q, C_FIVE);
          end
        end
      end
    end else begin
      s0_step = bcd_dec(s0_q, C_NINE);
      if (s0_q == 4'd0) begin
        s1_step = bcd_dec(s1_q, C_FIVE);
        if (s1_q == 4'd0) begin
          m0_step = bcd_dec(m0_q, C_NINE);
          if (m0_q == 4'd0) begin
            m1_step = bcd_dec(m1_q, C_FIVE);
          end
        end
      end
    end
  end

  // Next-state selection. Direction and run toggles land after the count
  // step is chosen, so a coincident tick uses the old direction and a
  // coincident pause still lets the tick complete.
  always_comb begin
    presc_d   = presc_q;
    m1_d      = m1_q;
    m0_d      = m0_q;
    s1_d      = s1_q;
    s0_d      = s0_q;
    up_d      = up_q ^ dir_tgl;
    running_d = running_q ^ run_tgl;
    if (clear) begin
      presc_d = '0;
      m1_d    = 4'd0;
      m0_d    = 4'd0;
      s1_d    = 4'd0;
      s0_d    = 4'd0;
    end else if (tick_w) begin
      presc_d = '0;
      m1_d    = m1_step;
      m0_d    = m0_step;
      s1_d    = s1_step;
      s0_d    = s0_step;
    end else if (running_q) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      presc_q   <= '0;
      m1_q      <= 4'd0;
      m0_q      <= 4'd0;
      s1_q      <= 4'd0;
      s0_q      <= 4'd0;
      up_q      <= 1'b1;
      running_q <= 1'b1;
    end else begin
      presc_q   <= presc_d;
      m1_q      <= m1_d;
      m0_q      <= m0_d;
      s1_q      <= s1_d;
      s0_q      <= s0_d;
      up_q      <= up_d;
      running_q <= running_d;
    end
  end

  assign m1      = m1_q;
  assign m0      = m0_q;
  assign s1      = s1_q;
  assign s0      = s0_q;
  assign up      = up_q;
  assign running = running_q;
  assign tick    = tick_w;
  assign wrap    = wrap_w;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_mmss_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_mmss_counter
// Description : Self-checking bench for stopwatch_mmss_counter with DIV = 4.
//               The reference keeps the time as a plain second count 0..3599
//               and a period phase, and derives the digits arithmetically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_mmss_counter;

  localparam int CLK_HZ  = 4;
  localparam int TICK_HZ = 1;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       run_tgl = 1'b0;
  logic       dir_tgl = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] m1, m0, s1, s0;
  logic       up, running, tick, wrap;

  stopwatch_mmss_counter #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .CLOCK_50 (clk),
    .reset_n  (reset_n),
    .run_tgl  (run_tgl),
    .dir_tgl  (dir_tgl),
    .clear    (clear),
    .m1       (m1),
    .m0       (m0),
    .s1       (s1),
    .s0       (s0),
    .up       (up),
    .running  (running),
    .tick     (tick),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: seconds since 00:00, phase within the current period.
  int   t_m;
  int   ph_m;
  logic up_m;
  logic run_m;

  logic obs_tick, obs_wrap;
  int   tick_cnt, wrap_cnt;

  task automatic check_eq(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] bcd_of(input int t);
    logic [15:0] v;
    v[15:12] = 4'(t / 600);
    v[11:8]  = 4'((t / 60) % 10);
    v[7:4]   = 4'((t % 60) / 10);
    v[3:0]   = 4'(t % 10);
    return v;
  endfunction

  function automatic logic [15:0] dut_digits();
    return {m1, m0, s1, s0};
  endfunction

  task automatic model_reset();
    t_m = 0; ph_m = 0; up_m = 1'b1; run_m = 1'b1;
  endtask

  // One clock: drive inputs, check every output at the falling edge against
  // the reference, then advance the reference at the rising edge.
  task automatic cyc(input logic rt, input logic dt, input logic cl, input logic rn);
    logic        tk, wr;
    logic [19:0] exp;
    run_tgl = rt; dir_tgl = dt; clear = cl; reset_n = rn;
    @(negedge clk);
    tk  = run_m && (ph_m == DIV - 1) && !cl;
    wr  = tk && (up_m ? (t_m == 3599) : (t_m == 0));
    exp = {bcd_of(t_m), up_m, run_m, tk, wr};
    check_eq("cycle", {m1, m0, s1, s0, up, running, tick, wrap}, exp);
    obs_tick = tick;
    obs_wrap = wrap;
    if (tick === 1'b1) tick_cnt++;
    if (wrap === 1'b1) wrap_cnt++;
    @(posedge clk);
    if (!rn) begin
      model_reset();
    end else begin
      if (cl) begin
        t_m = 0; ph_m = 0;
      end else if (tk) begin
        t_m  = up_m ? (t_m + 1) % 3600 : (t_m + 3599) % 3600;
        ph_m = 0;
      end else if (run_m) begin
        ph_m = ph_m + 1;
      end
      run_m = run_m ^ rt;
      up_m  = up_m ^ dt;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Bring the DUT out of its unknown power-up state.
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, then first ticks on cycles 4 and 8.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("reset_state", {dut_digits(), up, running, tick, wrap}, {16'h0000, 4'b1100});
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      check_eq("first_ticks", {19'd0, obs_tick}, {19'd0, (i == 4 || i == 8)});
      if (i == 4) check_eq("digits_0001", {4'd0, dut_digits()}, {4'd0, 16'h0001});
    end
    check_eq("digits_0002", {2'd0, dut_digits(), up, running}, {2'd0, 16'h0002, 2'b11});

    // 240 ticks from 00:00 reaches 04:00.
    idle((240 - 2) * DIV);
    check_eq("digits_0400", {4'd0, dut_digits()}, {4'd0, 16'h0400});

    // Preload 59:59, then wrap up to 00:00 with a single wrap pulse.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(3599 * DIV);
    check_eq("digits_5959", {4'd0, dut_digits()}, {4'd0, 16'h5959});
    wrap_cnt = 0;
    idle(DIV);
    check_eq("wrap_up_pulse", {19'd0, obs_wrap}, 20'd1);
    idle(1);
    check_eq("wrap_up_once", 20'(wrap_cnt), 20'd1);
    check_eq("digits_0000", {4'd0, dut_digits()}, {4'd0, 16'h0000});

    // Down from 00:00 wraps to 59:59; dir toggle coincident with a tick.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(2);
    check_eq("wrap_down_pulse", {19'd0, obs_wrap}, 20'd1);
    check_eq("digits_down_5959", {4'd0, dut_digits()}, {4'd0, 16'h5959});
    idle(2 * DIV);
    check_eq("digits_5957", {4'd0, dut_digits()}, {4'd0, 16'h5957});
    idle(DIV - 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    check_eq("dir_tick_old", {3'd0, dut_digits(), obs_tick}, {3'd0, 16'h5956, 1'b1});
    idle(DIV);
    check_eq("dir_tick_new", {3'd0, dut_digits(), up}, {3'd0, 16'h5957, 1'b1});

    // Pause at 00:05 with the prescaler at 2, then resume.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(5 * DIV + 2);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    tick_cnt = 0;
    idle(20);
    check_eq("pause_no_tick", 20'(tick_cnt), 20'd0);
    check_eq("pause_hold", {3'd0, dut_digits(), running}, {3'd0, 16'h0005, 1'b0});
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    check_eq("resume_edge", {19'd0, obs_tick}, 20'd0);
    idle(1);
    check_eq("resume_tick", {19'd0, obs_tick}, 20'd1);
    check_eq("digits_0006", {4'd0, dut_digits()}, {4'd0, 16'h0006});

    // Clear coincident with a tick at 12:34.
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    idle(754 * DIV);
    check_eq("digits_1234", {4'd0, dut_digits()}, {4'd0, 16'h1234});
    idle(DIV - 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("clear_kills_tick", {18'd0, obs_tick, obs_wrap}, 20'd0);
    check_eq("clear_digits", {2'd0, dut_digits(), up, running}, {2'd0, 16'h0000, 2'b11});
    tick_cnt = 0;
    idle(DIV - 1);
    check_eq("clear_prescaler", 20'(tick_cnt), 20'd0);
    idle(1);
    check_eq("clear_next_tick", {3'd0, dut_digits(), obs_tick}, {3'd0, 16'h0001, 1'b1});

    // Reset mid-period while counting down and paused.
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    check_eq("pre_reset_mode", {18'd0, up, running}, 20'd0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("midreset_state", {dut_digits(), up, running, tick, wrap}, {16'h0000, 4'b1100});
    tick_cnt = 0;
    idle(DIV - 1);
    check_eq("midreset_no_tick", 20'(tick_cnt), 20'd0);
    idle(1);
    check_eq("midreset_tick", {3'd0, dut_digits(), obs_tick}, {3'd0, 16'h0001, 1'b1});

    // Random command traffic, checked every cycle against the reference.
    for (int i = 0; i < 5000; i++) begin
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 59) == 0), ($urandom_range(0, 399) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_mmss_counter.md
Name: stopwatch_mmss_counter

Overview:
- Timebase and BCD minutes:seconds counter for the board stopwatch.
- Sits downstream of the key edge detector, which supplies single-cycle command pulses.
- Sits upstream of the four seven-segment decoders that drive HEX0..HEX3.
- Generates its own seconds tick from CLOCK_50 and counts up or down with run/pause, clear and direction control.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_HZ/TICK_HZ; DIV must be an integer >= 2.

Ports:
- CLOCK_50  input  1  system clock; all logic is on the rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of CLOCK_50.
- run_tgl  input  1  single-cycle pulse; toggles run/pause.
- dir_tgl  input  1  single-cycle pulse; toggles count direction.
- clear  input  1  single-cycle pulse; zeroes the time value.
- m1  output  4  BCD minutes tens, 0..5.
- m0  output  4  BCD minutes units, 0..9.
- s1  output  4  BCD seconds tens, 0..5.
- s0  output  4  BCD seconds units, 0..9.
- up  output  1  1 = counting up, 0 = counting down.
- running  output  1  1 = counting enabled.
- tick  output  1  one-cycle pulse on each count event.
- wrap  output  1  one-cycle pulse when the count wraps (59:59->00:00 up, or 00:00->59:59 down).

Behaviour:
- Reset (reset_n = 0 at a clock edge):
  - m1 = m0 = s1 = s0 = 0, prescaler = 0.
  - up = 1, running = 1, tick = 0, wrap = 0.
  - After reset the block counts up with no key press needed.
- Prescaler:
  - Counter 0..DIV-1, width $clog2(DIV); it advances only while running = 1.
  - When it equals DIV-1 and running = 1: tick = 1 that cycle (combinational from the registered state), and the prescaler returns to 0.
  - When running = 0 the prescaler holds its value, so resume continues the partial period.
- Count update:
  - Digits change at the same rising edge where tick = 1 and are visible the next cycle.
  - Up: s0 9->0 carries into s1; s1 5->0 carries into m0; m0 9->0 carries into m1; m1 5->0 and all digits wrap to 00:00.
  - Down: s0 0->9 borrows from s1; s1 0->5; m0 0->9; m1 0->5; 00:00 becomes 59:59.
  - wrap = 1 combinationally in the same cycle as the tick that causes the wrap.
- Commands:
  - run_tgl inverts running at the edge.
  - dir_tgl inverts up at the edge.
  - clear zeroes all digits and the prescaler; running and up are unchanged.
- Simultaneous events, in priority order:
  - reset_n = 0 overrides everything.
  - clear overrides a tick in the same cycle: the result is 00:00, and tick and wrap are forced to 0.
  - A tick and dir_tgl in the same cycle: the count uses the old direction, and the new direction applies from the next tick.
  - A tick and run_tgl in the same cycle: the tick completes, then the pause takes effect.
  - run_tgl, dir_tgl and clear together: all three take effect.
- Command pulses wider than one cycle toggle once per high cycle. Debounce and edge detection are the upstream block's job.
- Digits never hold non-BCD values, and 5 is the ceiling for s1 and m1. No illegal state is reachable. Recovery from any corrupt state is via reset only.
- Reset asserted mid-period discards the partial prescaler count.

Test Plan (bench uses CLK_HZ=4, TICK_HZ=1, so DIV=4):
- Reset, then 8 clocks -> tick high on cycles 4 and 8; digits 00:01 then 00:02; up = 1, running = 1.
- Run from 00:00 for 240 ticks -> 04:00. Preload via 3599 ticks to 59:59; the next tick -> 00:00 with wrap = 1 for exactly one cycle.
- At 00:00 pulse dir_tgl, then one tick -> 59:59 with wrap = 1. Two further ticks -> 59:57. Then pulse dir_tgl in the same cycle as a tick -> 59:56, and the following tick -> 59:57.
- At 00:05 with the prescaler at 2, pulse run_tgl, idle 20 clocks -> no tick, value stays 00:05. Pulse run_tgl again -> first tick exactly 2 clocks later, giving 00:06.
- At 12:34 assert clear in the same cycle as a tick -> 00:00 with tick = 0 and wrap = 0, and the next tick occurs 4 clocks later. Running and up are unchanged.
- Drop reset_n for one clock mid-period while counting down and paused -> all outputs return to their reset values, and counting resumes up 4 clocks after release.
